// File: rtl/hazard_fwd_unit_pkg.sv
// hazard_fwd_unit_pkg: operand select encodings, pipeline slot record and match helper
package hazard_fwd_unit_pkg;

    // SEL_ALT is pc on operand A and imm on operand B
    typedef enum logic [2:0] {
        SEL_RF   = 3'd0,
        SEL_ALT  = 3'd1,
        SEL_ALU  = 3'd2,
        SEL_DIN  = 3'd3,
        SEL_TRIM = 3'd4
    } op_sel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       load;
    } slot_t;

    function automatic logic slot_hit(slot_t s, logic [4:0] rs, logic use_rs);
        return s.valid && s.we && s.rd != 5'd0 && s.rd == rs && use_rs;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_sel.sv
// fwd_sel: nearest-first forwarding select and load-use detection for one operand
module fwd_sel
    import hazard_fwd_unit_pkg::*;
(
    input  slot_t      ex,
    input  slot_t      mem,
    input  logic [4:0] rs,
    input  logic       use_rs,
    input  logic       alt,
    output op_sel_t    sel,
    output logic       load_hit
);

    logic ex_hit, mem_hit;

    always_comb begin
        ex_hit   = slot_hit(ex, rs, use_rs);
        mem_hit  = slot_hit(mem, rs, use_rs);
        load_hit = !alt && ex_hit && ex.load;
        sel      = alt ? SEL_ALT :
                   (ex_hit && !ex.load) ? SEL_ALU :
                   mem_hit ? (mem.load ? SEL_TRIM : SEL_DIN) : SEL_RF;
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: tracks EX/MEM/WB destinations, registers ALU operand selects, detects load-use stalls
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_we,
    input  logic        id_is_load,
    input  logic        id_a_pc,
    input  logic        id_b_imm,
    input  logic        flush,
    output logic [2:0]  A_sel,
    output logic [2:0]  B_sel,
    output logic        stall,
    output logic [15:0] stall_cnt
);

    // slots[0]=EX, slots[1]=MEM, slots[2]=WB; WB is tracked but never forwards (write-first regfile)
    slot_t   slots [3];
    op_sel_t a_nxt, b_nxt;
    logic    a_load, b_load, take;

    fwd_sel u_a (
        .ex(slots[0]), .mem(slots[1]), .rs(id_rs1), .use_rs(id_use_rs1),
        .alt(id_a_pc), .sel(a_nxt), .load_hit(a_load)
    );

    fwd_sel u_b (
        .ex(slots[0]), .mem(slots[1]), .rs(id_rs2), .use_rs(id_use_rs2),
        .alt(id_b_imm), .sel(b_nxt), .load_hit(b_load)
    );

    assign stall = !rst && id_valid && !flush && (a_load || b_load);
    assign take  = id_valid && !stall && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            slots     <= '{default: '0};
            A_sel     <= SEL_RF;
            B_sel     <= SEL_RF;
            stall_cnt <= '0;
        end else begin
            slots[2]  <= slots[1];
            slots[1]  <= slots[0];
            slots[0]  <= take ? '{valid: 1'b1, rd: id_rd, we: id_we, load: id_is_load} : '0;
            A_sel     <= take ? a_nxt : SEL_RF;
            B_sel     <= take ? b_nxt : SEL_RF;
            stall_cnt <= stall_cnt + 16'(stall && stall_cnt != 16'hFFFF);
        end
    end

endmodule
